// File: rtl/sap_program_loader.sv
// SAP program loader: fills program RAM from a valid/ready word stream, then gates the CPU clock for run/step.
// Optional trailer checksum verification is enabled by defining SAP_LOADER_CHECKSUM_EN.
module sap_program_loader #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int DEPTH      = 256
) (
  input  logic                    i_clock,
  input  logic                    i_reset,
  input  logic                    i_load_start,
  input  logic [ADDR_WIDTH:0]     i_load_count,
  input  logic                    i_word_valid,
  input  logic [2*DATA_WIDTH-1:0] i_word,
  output logic                    o_word_ready,
  output logic                    o_ram_write,
  output logic [ADDR_WIDTH-1:0]   o_ram_address,
  output logic [2*DATA_WIDTH-1:0] o_ram_data,
  input  logic                    i_run,
  input  logic                    i_step,
  input  logic                    i_halt,
  output logic                    o_cpu_reset,
  output logic                    o_cpu_clock_enable,
  output logic [2:0]              o_state,
  output logic [ADDR_WIDTH:0]     o_loaded_count,
  output logic                    o_error
);
  localparam int WW = 2 * DATA_WIDTH;
  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
`ifdef SAP_LOADER_CHECKSUM_EN
    CHECK  = 3'd2,
`endif
    READY  = 3'd3,
    RUN    = 3'd4,
    PAUSED = 3'd5,
    HALTED = 3'd6
  } state_t;

  state_t                state_q;
  logic                  ready_q;
  logic                  write_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [WW-1:0]         data_q;
  logic [CW-1:0]         count_q;
  logic [CW-1:0]         loaded_q;
  logic [CW-1:0]         loaded_d;
  logic                  error_q;
  logic                  cpu_reset_q;
  logic                  enable_q;
  logic                  accept;
  logic                  count_bad;
  logic                  load_cmd;
`ifdef SAP_LOADER_CHECKSUM_EN
  logic [WW-1:0]         sum_q;
`endif

  assign accept    = i_word_valid & ready_q;
  assign loaded_d  = loaded_q + {{(CW-1){1'b0}}, 1'b1};
  assign count_bad = (i_load_count == {CW{1'b0}}) | (i_load_count > DEPTH_C);
  // A load request only counts in the resting states; halt outranks it while PAUSED.
  assign load_cmd  = i_load_start & ((state_q == IDLE) | (state_q == READY) |
                                     (state_q == HALTED) | ((state_q == PAUSED) & ~i_halt));

  // Loader/run-control FSM with all outputs registered.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q     <= IDLE;
      ready_q     <= 1'b0;
      write_q     <= 1'b0;
      addr_q      <= {ADDR_WIDTH{1'b0}};
      data_q      <= {WW{1'b0}};
      count_q     <= {CW{1'b0}};
      loaded_q    <= {CW{1'b0}};
      error_q     <= 1'b0;
      cpu_reset_q <= 1'b1;
      enable_q    <= 1'b0;
`ifdef SAP_LOADER_CHECKSUM_EN
      sum_q       <= {WW{1'b0}};
`endif
    end else begin
      write_q  <= 1'b0;
      enable_q <= 1'b0;
      if (load_cmd) begin
        cpu_reset_q <= 1'b1;
        if (count_bad) begin
          error_q <= 1'b1;
          state_q <= IDLE;
          ready_q <= 1'b0;
        end else begin
          error_q  <= 1'b0;
          state_q  <= LOAD;
          ready_q  <= 1'b1;
          addr_q   <= {ADDR_WIDTH{1'b0}};
          loaded_q <= {CW{1'b0}};
          count_q  <= i_load_count;
`ifdef SAP_LOADER_CHECKSUM_EN
          sum_q    <= {WW{1'b0}};
`endif
        end
      end else begin
        case (state_q)
          LOAD: begin
            if (accept) begin
              // Word k lands at address k, so the pre-increment count is the address.
              write_q  <= 1'b1;
              addr_q   <= loaded_q[ADDR_WIDTH-1:0];
              data_q   <= i_word;
              loaded_q <= loaded_d;
`ifdef SAP_LOADER_CHECKSUM_EN
              sum_q    <= sum_q + i_word;
              if (loaded_d == count_q) begin
                state_q <= CHECK;
              end
`else
              if (loaded_d == count_q) begin
                state_q <= READY;
                ready_q <= 1'b0;
              end
`endif
            end
          end
`ifdef SAP_LOADER_CHECKSUM_EN
          CHECK: begin
            if (accept) begin
              ready_q <= 1'b0;
              if (i_word == sum_q) begin
                state_q <= READY;
              end else begin
                error_q <= 1'b1;
                state_q <= IDLE;
              end
            end
          end
`endif
          READY: begin
            if (i_run) begin
              state_q     <= RUN;
              enable_q    <= 1'b1;
              cpu_reset_q <= 1'b0;
            end else if (i_step) begin
              state_q     <= PAUSED;
              enable_q    <= 1'b1;
              cpu_reset_q <= 1'b0;
            end
          end
          RUN: begin
            if (i_halt) begin
              state_q <= HALTED;
            end else if (!i_run) begin
              state_q <= PAUSED;
            end else begin
              enable_q <= 1'b1;
            end
          end
          PAUSED: begin
            if (i_halt) begin
              state_q <= HALTED;
            end else if (i_run) begin
              state_q  <= RUN;
              enable_q <= 1'b1;
            end else if (i_step) begin
              enable_q <= 1'b1;
            end
          end
          IDLE, HALTED: begin
          end
          default: begin
            state_q     <= IDLE;
            ready_q     <= 1'b0;
            cpu_reset_q <= 1'b1;
          end
        endcase
      end
    end
  end

  assign o_word_ready       = ready_q;
  assign o_ram_write        = write_q;
  assign o_ram_address      = addr_q;
  assign o_ram_data         = data_q;
  assign o_cpu_reset        = cpu_reset_q;
  assign o_cpu_clock_enable = enable_q;
  assign o_state            = state_q;
  assign o_loaded_count     = loaded_q;
  assign o_error            = error_q;

endmodule

// File: tb/tb_sap_program_loader.sv
// Self-checking bench for sap_program_loader: table-driven loads, hand sequences, randomized run control.
module tb_sap_program_loader;
  localparam int DW = 8;
  localparam int AW = 8;
  localparam int DEPTH = 256;
  localparam int WW = 2 * DW;
  localparam int CW = AW + 1;
`ifdef SAP_LOADER_CHECKSUM_EN
  localparam logic CK = 1'b1;
`else
  localparam logic CK = 1'b0;
`endif
  localparam logic [2:0] S_IDLE = 3'd0, S_LOAD = 3'd1, S_CHECK = 3'd2, S_READY = 3'd3;
  localparam logic [2:0] S_RUN = 3'd4, S_PAUSED = 3'd5, S_HALTED = 3'd6;

  logic i_clock = 1'b0;
  logic i_reset, i_load_start, i_word_valid, i_run, i_step, i_halt;
  logic [CW-1:0] i_load_count;
  logic [WW-1:0] i_word;
  logic o_word_ready, o_ram_write, o_cpu_reset, o_cpu_clock_enable, o_error;
  logic [AW-1:0] o_ram_address;
  logic [WW-1:0] o_ram_data;
  logic [2:0] o_state;
  logic [CW-1:0] o_loaded_count;

  always #5 i_clock = ~i_clock;

  sap_program_loader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
    .i_clock(i_clock), .i_reset(i_reset), .i_load_start(i_load_start),
    .i_load_count(i_load_count), .i_word_valid(i_word_valid), .i_word(i_word),
    .o_word_ready(o_word_ready), .o_ram_write(o_ram_write), .o_ram_address(o_ram_address),
    .o_ram_data(o_ram_data), .i_run(i_run), .i_step(i_step), .i_halt(i_halt),
    .o_cpu_reset(o_cpu_reset), .o_cpu_clock_enable(o_cpu_clock_enable), .o_state(o_state),
    .o_loaded_count(o_loaded_count), .o_error(o_error));

  int checks = 0;
  int errors = 0;
  logic [WW-1:0] exp_words[$];
  int exp_idx = 0;
  int wr_count = 0;
  bit hs_prev = 1'b0;
  bit trailer_phase = 1'b0;
  bit mon_on = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge i_clock);
  endtask

  // Write scoreboard: every strobe must follow a data handshake by exactly one cycle.
  always @(posedge i_clock) begin
    if (mon_on) begin
      chk("write_strobe", {31'd0, o_ram_write}, {31'd0, hs_prev});
      if (o_ram_write) begin
        chk("write_in_range", {31'd0, exp_idx < exp_words.size()}, 32'd1);
        if (exp_idx < exp_words.size()) begin
          chk("write_addr", {24'd0, o_ram_address}, exp_idx);
          chk("write_data", {16'd0, o_ram_data}, {16'd0, exp_words[exp_idx]});
        end
        exp_idx++;
        wr_count++;
      end
      hs_prev = i_word_valid && o_word_ready && !trailer_phase && !i_reset;
    end
  end

  function automatic logic [WW-1:0] word_sum();
    logic [WW-1:0] s = '0;
    foreach (exp_words[k]) s = s + exp_words[k];
    return s;
  endfunction

  task automatic check_reset_values();
    chk("rst_state", {29'd0, o_state}, {29'd0, S_IDLE});
    chk("rst_cpu_reset", {31'd0, o_cpu_reset}, 32'd1);
    chk("rst_enable", {31'd0, o_cpu_clock_enable}, 32'd0);
    chk("rst_write", {31'd0, o_ram_write}, 32'd0);
    chk("rst_ready", {31'd0, o_word_ready}, 32'd0);
    chk("rst_error", {31'd0, o_error}, 32'd0);
    chk("rst_addr", {24'd0, o_ram_address}, 32'd0);
    chk("rst_data", {16'd0, o_ram_data}, 32'd0);
    chk("rst_loaded", {23'd0, o_loaded_count}, 32'd0);
  endtask

  task automatic start_load(input logic [CW-1:0] cnt);
    exp_idx = 0;
    wr_count = 0;
    i_load_start = 1'b1;
    i_load_count = cnt;
    tick();
    i_load_start = 1'b0;
  endtask

  // vmode 0: back-to-back valid, 1: valid every third cycle, 2: random valid
  task automatic stream(input int stop, input int vmode);
    int idx = 0;
    bit rdy, v;
    for (int c = 0; c < 3000; c++) begin
      rdy = o_word_ready;
      case (vmode)
        0: v = 1'b1;
        1: v = (c % 3 == 0);
        default: v = 1'($urandom_range(0, 1));
      endcase
      i_word_valid = v;
      i_word = exp_words[idx];
      tick();
      if (v && rdy) idx++;
      if (idx == stop) break;
    end
    i_word_valid = 1'b0;
    chk("stream_done", idx, stop);
  endtask

  task automatic send_trailer(input logic [WW-1:0] w);
    bit rdy;
    bit done = 1'b0;
    trailer_phase = 1'b1;
    i_word = w;
    for (int c = 0; c < 20 && !done; c++) begin
      rdy = o_word_ready;
      i_word_valid = 1'b1;
      tick();
      if (rdy) done = 1'b1;
    end
    i_word_valid = 1'b0;
    trailer_phase = 1'b0;
    chk("trailer_accepted", {31'd0, done}, 32'd1);
  endtask

  task automatic finish_check(input int n);
    chk("ready_after_last", {31'd0, o_word_ready}, {31'd0, CK});
`ifdef SAP_LOADER_CHECKSUM_EN
    chk("check_state", {29'd0, o_state}, {29'd0, S_CHECK});
    send_trailer(word_sum());
    chk("ready_after_trailer", {31'd0, o_word_ready}, 32'd0);
`endif
    chk("load_state", {29'd0, o_state}, {29'd0, S_READY});
    chk("load_count", {23'd0, o_loaded_count}, n);
    chk("load_error", {31'd0, o_error}, 32'd0);
    chk("load_cpu_reset", {31'd0, o_cpu_reset}, 32'd1);
    chk("load_enable", {31'd0, o_cpu_clock_enable}, 32'd0);
    tick();
    chk("write_total", wr_count, n);
  endtask

  task automatic random_load(input int n);
    exp_words.delete();
    for (int k = 0; k < n; k++) exp_words.push_back(WW'($urandom));
    start_load(CW'(n));
    chk("rl_state", {29'd0, o_state}, {29'd0, S_LOAD});
    stream(n, 2);
    finish_check(n);
  endtask

  typedef struct {
    logic [CW-1:0] cnt;
    logic          err;
    logic [2:0]    st;
    int            vmode;
  } vec_t;

  vec_t vt[8];
  bit running, halted, en_exp;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    i_reset = 1'b1; i_load_start = 1'b0; i_load_count = '0; i_word_valid = 1'b0;
    i_word = '0; i_run = 1'b0; i_step = 1'b0; i_halt = 1'b0;
    tick(); tick();
    i_reset = 1'b0;
    check_reset_values();
    mon_on = 1'b1;

    // Back-to-back load of four known words
    exp_words = '{16'h00FF, 16'h017F, 16'h0201, 16'h0702};
    start_load(9'd4);
    chk("t1_state", {29'd0, o_state}, {29'd0, S_LOAD});
    chk("t1_ready", {31'd0, o_word_ready}, 32'd1);
    stream(4, 0);
    finish_check(4);

    vt[0] = '{9'd0,   1'b1, S_IDLE, 0};
    vt[1] = '{9'd257, 1'b1, S_IDLE, 0};
    vt[2] = '{9'd3,   1'b0, S_LOAD, 1};
    vt[3] = '{9'd511, 1'b1, S_IDLE, 0};
    vt[4] = '{9'd1,   1'b0, S_LOAD, 0};
    vt[5] = '{9'd256, 1'b0, S_LOAD, 2};
    vt[6] = '{9'd257, 1'b1, S_IDLE, 0};
    vt[7] = '{9'd2,   1'b0, S_LOAD, 2};
    foreach (vt[i]) begin
      exp_words.delete();
      if (!vt[i].err) for (int k = 0; k < int'(vt[i].cnt); k++) exp_words.push_back(WW'($urandom));
      start_load(vt[i].cnt);
      chk("vec_state", {29'd0, o_state}, {29'd0, vt[i].st});
      chk("vec_error", {31'd0, o_error}, {31'd0, vt[i].err});
      chk("vec_ready", {31'd0, o_word_ready}, {31'd0, !vt[i].err});
      chk("vec_cpu_reset", {31'd0, o_cpu_reset}, 32'd1);
      if (!vt[i].err) begin
        stream(int'(vt[i].cnt), vt[i].vmode);
        finish_check(int'(vt[i].cnt));
      end else begin
        i_word_valid = 1'b1;
        repeat (3) tick();
        i_word_valid = 1'b0;
        chk("vec_err_state", {29'd0, o_state}, {29'd0, S_IDLE});
        chk("vec_err_sticky", {31'd0, o_error}, 32'd1);
        chk("vec_err_writes", wr_count, 0);
      end
    end

    // Two steps, five run cycles, then halt
    for (int s = 0; s < 2; s++) begin
      i_step = 1'b1; tick(); i_step = 1'b0;
      chk("step_enable", {31'd0, o_cpu_clock_enable}, 32'd1);
      chk("step_state", {29'd0, o_state}, {29'd0, S_PAUSED});
      chk("step_cpu_reset", {31'd0, o_cpu_reset}, 32'd0);
      tick();
      chk("step_enable_off", {31'd0, o_cpu_clock_enable}, 32'd0);
    end
    i_run = 1'b1;
    for (int s = 0; s < 5; s++) begin
      tick();
      chk("run_enable", {31'd0, o_cpu_clock_enable}, 32'd1);
      chk("run_state", {29'd0, o_state}, {29'd0, S_RUN});
    end
    i_halt = 1'b1; tick(); i_halt = 1'b0; i_run = 1'b0;
    chk("halt_enable", {31'd0, o_cpu_clock_enable}, 32'd0);
    chk("halt_state", {29'd0, o_state}, {29'd0, S_HALTED});
    chk("halt_cpu_reset", {31'd0, o_cpu_reset}, 32'd0);
    i_step = 1'b1; tick(); i_step = 1'b0;
    i_run = 1'b1; tick(); i_run = 1'b0;
    chk("halted_hold_enable", {31'd0, o_cpu_clock_enable}, 32'd0);
    chk("halted_hold_state", {29'd0, o_state}, {29'd0, S_HALTED});

    // Reset after two of four words, then a clean reload (load_start ignored mid-load)
    exp_words.delete();
    for (int k = 0; k < 4; k++) exp_words.push_back(WW'($urandom));
    start_load(9'd4);
    stream(2, 0);
    i_reset = 1'b1; tick(); i_reset = 1'b0;
    check_reset_values();
    exp_words.delete();
    for (int k = 0; k < 4; k++) exp_words.push_back(WW'($urandom));
    start_load(9'd4);
    i_load_start = 1'b1; i_load_count = 9'd0; tick(); i_load_start = 1'b0;
    chk("ignore_start_state", {29'd0, o_state}, {29'd0, S_LOAD});
    chk("ignore_start_error", {31'd0, o_error}, 32'd0);
    stream(4, 0);
    finish_check(4);

    // Halt and step in the same cycle: halt wins
    i_step = 1'b1; tick(); i_step = 1'b0; tick();
    i_step = 1'b1; i_halt = 1'b1; tick(); i_step = 1'b0; i_halt = 1'b0;
    chk("halt_step_enable", {31'd0, o_cpu_clock_enable}, 32'd0);
    chk("halt_step_state", {29'd0, o_state}, {29'd0, S_HALTED});

    // Randomized run control against rule-level model
    for (int r = 0; r < 4; r++) begin
      random_load($urandom_range(1, 8));
      i_step = 1'b1; tick(); i_step = 1'b0;
      chk("rr_step_enable", {31'd0, o_cpu_clock_enable}, 32'd1);
      running = 1'b0; halted = 1'b0;
      for (int c = 0; c < 50; c++) begin
        if ($urandom_range(0, 3) == 0) i_run = ~i_run;
        i_step = ($urandom_range(0, 2) == 0);
        i_halt = ($urandom_range(0, 29) == 0);
        tick();
        en_exp = !halted && !i_halt && (i_run || (i_step && !running));
        running = !halted && !i_halt && i_run;
        halted = halted || i_halt;
        chk("rr_enable", {31'd0, o_cpu_clock_enable}, {31'd0, en_exp});
        chk("rr_state", {29'd0, o_state}, halted ? {29'd0, S_HALTED} : (running ? {29'd0, S_RUN} : {29'd0, S_PAUSED}));
        chk("rr_cpu_reset", {31'd0, o_cpu_reset}, 32'd0);
      end
      i_run = 1'b0; i_step = 1'b0; i_halt = 1'b0;
      tick();
      chk("rr_settle", {29'd0, o_state}, halted ? {29'd0, S_HALTED} : {29'd0, S_PAUSED});
    end

`ifdef SAP_LOADER_CHECKSUM_EN
    exp_words = '{16'h0001, 16'h0002};
    start_load(9'd2);
    stream(2, 0);
    chk("ck_state_check", {29'd0, o_state}, {29'd0, S_CHECK});
    send_trailer(16'h0003);
    chk("ck_good_state", {29'd0, o_state}, {29'd0, S_READY});
    chk("ck_good_error", {31'd0, o_error}, 32'd0);
    tick();
    chk("ck_good_writes", wr_count, 2);
    start_load(9'd2);
    stream(2, 0);
    send_trailer(16'h0004);
    chk("ck_bad_state", {29'd0, o_state}, {29'd0, S_IDLE});
    chk("ck_bad_error", {31'd0, o_error}, 32'd1);
    tick();
    chk("ck_bad_writes", wr_count, 2);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sap_program_loader.md
# sap_program_loader

Parametrised program loader and run controller for the SAP system. It replaces hand-sequenced RAM writes with a valid/ready word stream that fills program RAM at sequential addresses. It holds the CPU in reset while loading, then gates the CPU clock for free-run or single-step execution until the controller raises halt. It sits between the host/UART front end, the `given_ram` program port, and the controller clock/reset inputs.

## Interface
Parameters:
- `DATA_WIDTH`, 8, operand width; one program word is `{opcode, operand}`.
- `ADDR_WIDTH`, 8, RAM address width.
- `DEPTH`, 256, usable RAM words; must be ≤ 2^ADDR_WIDTH.

Ports (`WW` = 2*DATA_WIDTH):
- `i_clock`  in  1  system clock; single clock domain.
- `i_reset`  in  1  synchronous, active-high reset.
- `i_load_start`  in  1  pulse that starts a load of `i_load_count` words.
- `i_load_count`  in  ADDR_WIDTH+1  word count, sampled with `i_load_start`.
- `i_word_valid`  in  1  stream word valid.
- `i_word`  in  WW  stream word.
- `o_word_ready`  out  1  loader accepts a word this cycle.
- `o_ram_write`  out  1  one-cycle RAM program-port write strobe.
- `o_ram_address`  out  ADDR_WIDTH  RAM program address.
- `o_ram_data`  out  WW  RAM program data.
- `i_run`  in  1  level; free-run while high.
- `i_step`  in  1  pulse; one CPU clock-enable cycle.
- `i_halt`  in  1  controller `o_halt`.
- `o_cpu_reset`  out  1  reset to PC, registers, and controller.
- `o_cpu_clock_enable`  out  1  CPU clock enable.
- `o_state`  out  3  current state encoding.
- `o_loaded_count`  out  ADDR_WIDTH+1  words written in the last load.
- `o_error`  out  1  sticky error flag for a bad count or checksum.

## Operation
- State encodings: IDLE=0, LOAD=1, CHECK=2, READY=3, RUN=4, PAUSED=5, HALTED=6.
- Reset values:
  - state IDLE.
  - `o_cpu_reset`=1.
  - `o_cpu_clock_enable`, `o_ram_write`, `o_word_ready`, and `o_error` all 0.
  - `o_ram_address`, `o_ram_data`, and `o_loaded_count` all 0.
- Command priority per cycle: `i_halt` > `i_load_start` > `i_run` > `i_step`.
- IDLE, READY, PAUSED, HALTED on `i_load_start`:
  - If count is 0 or greater than DEPTH: set `o_error`=1 and go to or stay in IDLE.
  - Otherwise: go to LOAD, clear `o_error`, zero the address and `o_loaded_count`, and assert `o_cpu_reset`=1.
- LOAD:
  - `o_word_ready`=1.
  - Each `i_word_valid && o_word_ready` handshake writes `i_word` at the next address and increments `o_loaded_count`.
  - `i_load_start` is ignored during LOAD.
  - After the last word: go to CHECK (macro defined) or READY.
- READY: `o_cpu_reset`=1 and clock enable off. `i_run` goes to RUN. `i_step` goes to PAUSED with one enable pulse.
- RUN:
  - `o_cpu_reset`=0 and `o_cpu_clock_enable`=1.
  - `i_run` low goes to PAUSED.
  - `i_halt` goes to HALTED.
  - `i_step` is ignored.
- PAUSED:
  - Clock enable is off.
  - `i_step` gives exactly one enable cycle per pulse.
  - `i_run` goes to RUN.
  - `i_halt` goes to HALTED.
- HALTED:
  - Clock enable is off. `o_cpu_reset`=0, so CPU state is preserved for inspection.
  - Only `i_load_start` or `i_reset` leaves this state.
- `i_reset` mid-LOAD abandons the load and returns everything to its reset values. RAM contents are untouched.

## Timing
- All outputs are registered.
- Write latency: a handshake in cycle N gives `o_ram_write`=1 in cycle N+1, with the matching address and data. The address increments after each write.
- Throughput: one word per cycle with back-to-back valid; no bubbles.
- `o_word_ready` drops in the cycle after the final accepted word (CHECK keeps it high for one more word).
- `i_run` sampled in cycle N gives `o_cpu_clock_enable`=1 from cycle N+1.
- `i_halt` sampled in cycle N gives enable=0 from cycle N+1.
- `i_step` sampled in cycle N gives enable=1 in cycle N+1 only.
- `i_halt` and `i_step` in the same cycle: halt wins and no enable pulse is issued.
- Address never wraps because count ≤ DEPTH is enforced at start.

## Configuration
- `SAP_LOADER_CHECKSUM_EN` defined:
  - LOAD accumulates the sum of all words mod 2^WW.
  - CHECK accepts one extra word, which is not written to RAM.
  - If it equals the sum: go to READY. Otherwise: set `o_error`=1 and go to IDLE.
- Undefined: the CHECK state is absent, LOAD goes directly to READY, and no accumulator is built.

## Test plan
- Reset, then load count=4 with words {0x00FF, 0x017F, 0x0201, 0x0702} streamed back-to-back. Required: 4 write strobes at addresses 0–3 on consecutive cycles, `o_loaded_count`=4, state READY, `o_cpu_reset`=1.
- Load count=0, then count=DEPTH+1. Required: `o_error`=1 and state IDLE each time, with no write strobes.
- Throttled valid (every third cycle) with count=3. Required: exactly 3 writes, each one cycle after its handshake.
- From READY, pulse `i_step` twice, then hold `i_run` for 5 cycles, then raise `i_halt`. Required: two single-cycle enables, then 5 continuous enable cycles. Required: enable low the cycle after halt, state HALTED, and `o_cpu_reset`=0.
- Assert `i_reset` after 2 of 4 words. Required: state IDLE and all outputs at reset values; a subsequent load works normally.
- With the macro defined, load 2 words 0x0001 and 0x0002:
  - trailer 0x0003: state READY.
  - trailer 0x0004: `o_error`=1 and state IDLE.
